// File: rtl/mult_bcd_converter.sv
// mult_bcd_converter: serial double-dabble binary-to-packed-BCD converter for MULT products
module mult_bcd_converter #(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5,
    parameter int CNT_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [IN_W-1:0]      bin;
    logic [4*DIGITS-1:0]  scratch;
    logic [4*DIGITS-1:0]  adj;
    logic [CNT_W-1:0]     cnt;

    // Add-3 correction applied to every digit independently, no inter-digit carry
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3 : scratch[4*d +: 4];
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Control FSM plus datapath: capture, IN_W adjust-and-shift steps, then publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin       <= '0;
            scratch   <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    bin     <= in_data;
                    scratch <= '0;
                    cnt     <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {scratch, bin} <= {adj[4*DIGITS-2:0], bin, 1'b0};
                    cnt            <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(IN_W - 1)) state <= DONE;
                end
                DONE: begin
                    out_bcd   <= scratch;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_bcd_converter.sv
// tb_mult_bcd_converter: scoreboard bench for the serial binary-to-BCD converter
module tb_mult_bcd_converter;
    localparam int IN_W = 16;
    localparam int DIGITS = 5;
    localparam int LAT = IN_W + 1;

    logic                 clk = 0;
    logic                 rst_n = 0;
    logic                 in_valid = 0;
    logic [IN_W-1:0]      in_data = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [4*DIGITS-1:0]  out_bcd;
    logic                 busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_count = 0;
    int last_acc = 0;
    int prev_acc = 0;

    logic [4*DIGITS-1:0] exp_q[$];
    int                  val_q[$];
    int                  acc_q[$];

    mult_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_bcd(out_bcd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Decimal reference: digit i is floor(v / 10^i) mod 10
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Monitor first, then note any handshake that the next rising edge will accept
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
            else begin
                logic [4*DIGITS-1:0] e;
                int v, a, dv, p, okd;
                e = exp_q.pop_front();
                v = val_q.pop_front();
                a = acc_q.pop_front();
                chk("out_bcd", 64'(out_bcd), 64'(e));
                chk("latency", 64'(cyc - a), 64'(LAT));
                dv = 0; p = 1; okd = 1;
                for (int i = 0; i < DIGITS; i++) begin
                    if (out_bcd[4*i +: 4] > 4'd9) okd = 0;
                    dv = dv + int'(out_bcd[4*i +: 4]) * p;
                    p = p * 10;
                end
                chk("nibbles_le_9", 64'(okd), 1);
                chk("decimal_value", 64'(dv), 64'(v));
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(to_bcd(int'(in_data)));
            val_q.push_back(int'(in_data));
            acc_q.push_back(cyc + 1);
            prev_acc = last_acc;
            last_acc = cyc + 1;
            acc_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input int v);
        wait_ready();
        in_valid = 1;
        in_data = IN_W'(v);
        tick();
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 0);
        tick();
    endtask

    initial begin
        int n0, n;
        tick();
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_bcd", 64'(out_bcd), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        rst_n = 1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 1);

        send(555);
        chk("busy_after_accept", 64'(busy), 1);
        drain();
        chk("hold_out_bcd", 64'(out_bcd), 64'h00555);

        send(0);
        drain();
        send(65535);
        drain();

        n0 = acc_count;
        wait_ready();
        in_valid = 1;
        in_data = 999;
        n = 0;
        while (acc_count < n0 + 1 && n < 50) begin tick(); n++; end
        in_data = 1000;
        n = 0;
        while (acc_count < n0 + 2 && n < 50) begin tick(); n++; end
        in_valid = 0;
        chk("b2b_accepts", 64'(acc_count - n0), 2);
        chk("accept_interval", 64'(last_acc - prev_acc), 64'(IN_W + 2));
        drain();

        send(255);
        repeat (3) tick();
        in_valid = 1;
        in_data = 12345;
        tick();
        in_valid = 0;
        chk("ignored_in_ready", 64'(in_ready), 0);
        repeat (5) tick();
        chk("shift_in_ready", 64'(in_ready), 0);
        drain();
        chk("ignored_out_bcd", 64'(out_bcd), 64'h00255);

        send(4321);
        repeat (4) tick();
        rst_n = 0;
        exp_q.delete();
        val_q.delete();
        acc_q.delete();
        #1;
        chk("abort_out_bcd", 64'(out_bcd), 0);
        chk("abort_busy", 64'(busy), 0);
        repeat (5) tick();
        chk("abort_out_valid", 64'(out_valid), 0);
        rst_n = 1;
        tick();
        chk("abort_in_ready", 64'(in_ready), 1);
        repeat (25) tick();
        chk("abort_no_output", 64'(out_bcd), 0);
        send(42);
        drain();

        for (int i = 0; i < 1000; i++) begin
            send(int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 20)) tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
